// File: rtl/stopwatch_lap_cu_if.sv
// Request/response bundle between the stopwatch front panel and its lap control unit.
// master: the side issuing requests and supplying the live time word.
// slave : the control unit.
interface stopwatch_lap_cu_if #(
  parameter int unsigned TIME_W = 24,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              i_clear;
  logic              i_runstop;
  logic              i_save;
  logic              i_restore;
  logic [TIME_W-1:0] i_time;

  logic              o_runstop;
  logic              o_clear;
  logic              o_save;
  logic              o_restore;
  logic [TIME_W-1:0] o_recall_time;
  logic [CNT_W-1:0]  o_lap_count;
  logic              o_full;
  logic              o_ovf;

  modport master (
    output i_clear, i_runstop, i_save, i_restore, i_time,
    input  o_runstop, o_clear, o_save, o_restore, o_recall_time,
           o_lap_count, o_full, o_ovf
  );

  modport slave (
    input  i_clear, i_runstop, i_save, i_restore, i_time,
    output o_runstop, o_clear, o_save, o_restore, o_recall_time,
           o_lap_count, o_full, o_ovf
  );
endinterface

// File: rtl/stopwatch_lap_cu.sv
// Stopwatch control unit with a circular lap buffer.
// Controls run/stop of the time datapath, clears it, stores lap times and
// recalls them newest-first, wrapping from the oldest back to the newest.
// Optional feature macro: LAP_OVERWRITE_EN -- when defined, a save into a full
// buffer overwrites the oldest lap instead of being rejected with o_ovf.
module stopwatch_lap_cu #(
  parameter int unsigned TIME_W = 24,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_lap_cu_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_RUN     = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_SAVE    = 3'd3,
    ST_RESTORE = 3'd4
  } state_e;

  state_e            state_q, state_d;

  // Registered outputs and their next values
  logic              runstop_q, runstop_d;
  logic              clear_q, clear_d;
  logic              save_q, save_d;
  logic              restore_q, restore_d;
  logic [TIME_W-1:0] recall_q, recall_d;
  logic              ovf_q, ovf_d;
  logic              full_q, full_d;

  // Lap bookkeeping
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              ret_run_q, ret_run_d;
  logic              mem_we;

  logic [TIME_W-1:0] lap_mem [DEPTH];

  // Oldest and newest occupied slots, used to wrap the recall pointer.
  // With a full buffer the count's low bits are zero, so oldest == wr_ptr.
  logic [PTR_W-1:0]  oldest_ptr, newest_ptr;
  assign oldest_ptr = wr_ptr_q - PTR_W'(count_q);
  assign newest_ptr = wr_ptr_q - PTR_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_STOP;
    else      state_q <= state_d;
  end

  // Next-state logic with clear > runstop > save > restore priority
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (bus.i_clear)                              state_d = ST_CLEAR;
        else if (bus.i_runstop)                       state_d = ST_RUN;
        else if (bus.i_save)                          state_d = ST_SAVE;
        else if (bus.i_restore && (count_q != '0))    state_d = ST_RESTORE;
      end
      ST_RUN: begin
        if (bus.i_runstop)   state_d = ST_STOP;
        else if (bus.i_save) state_d = ST_SAVE;
      end
      ST_CLEAR:   state_d = ST_STOP;
      ST_SAVE:    state_d = ret_run_q ? ST_RUN : ST_STOP;
      ST_RESTORE: state_d = ST_STOP;
      default:    state_d = ST_STOP;
    endcase
  end

  // Next values of outputs, counters and pointers for the current state
  always_comb begin
    runstop_d = runstop_q;
    clear_d   = 1'b0;
    save_d    = 1'b0;
    restore_d = 1'b0;
    recall_d  = '0;
    ovf_d     = 1'b0;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ret_run_d = ret_run_q;
    mem_we    = 1'b0;
    case (state_q)
      ST_STOP: begin
        runstop_d = 1'b0;
        ret_run_d = 1'b0;
      end
      ST_RUN: begin
        runstop_d = 1'b1;
        ret_run_d = 1'b1;
      end
      ST_CLEAR: begin
        runstop_d = 1'b0;
        clear_d   = 1'b1;
        count_d   = '0;
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
      end
      ST_SAVE: begin
        // runstop holds its value so a lap taken while running never pauses the datapath
        if (!full_q) begin
          mem_we   = 1'b1;
          save_d   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          rd_ptr_d = wr_ptr_q;
          count_d  = count_q + CNT_W'(1);
        end else begin
`ifdef LAP_OVERWRITE_EN
          mem_we   = 1'b1;
          save_d   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          rd_ptr_d = wr_ptr_q;
`else
          ovf_d    = 1'b1;
`endif
        end
      end
      ST_RESTORE: begin
        runstop_d = 1'b0;
        restore_d = 1'b1;
        recall_d  = lap_mem[rd_ptr_q];
        rd_ptr_d  = (rd_ptr_q == oldest_ptr) ? newest_ptr : (rd_ptr_q - PTR_W'(1));
      end
      default: begin
        runstop_d = 1'b0;
      end
    endcase
    full_d = (count_d == CNT_W'(DEPTH));
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      runstop_q <= 1'b0;
      clear_q   <= 1'b0;
      save_q    <= 1'b0;
      restore_q <= 1'b0;
      recall_q  <= '0;
      ovf_q     <= 1'b0;
      full_q    <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ret_run_q <= 1'b0;
    end else begin
      runstop_q <= runstop_d;
      clear_q   <= clear_d;
      save_q    <= save_d;
      restore_q <= restore_d;
      recall_q  <= recall_d;
      ovf_q     <= ovf_d;
      full_q    <= full_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ret_run_q <= ret_run_d;
    end
  end

  // Lap storage; contents are never readable while the count is zero, so no reset
  always_ff @(posedge clk) begin
    if (mem_we) lap_mem[wr_ptr_q] <= bus.i_time;
  end

  assign bus.o_runstop     = runstop_q;
  assign bus.o_clear       = clear_q;
  assign bus.o_save        = save_q;
  assign bus.o_restore     = restore_q;
  assign bus.o_recall_time = recall_q;
  assign bus.o_lap_count   = count_q;
  assign bus.o_full        = full_q;
  assign bus.o_ovf         = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_cu.sv
// Directed bench for the stopwatch lap control unit (DEPTH=4, TIME_W=24).
module tb_stopwatch_lap_cu;

  localparam int unsigned TIME_W = 24;
  localparam int unsigned DEPTH  = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  stopwatch_lap_cu_if #(.TIME_W(TIME_W), .DEPTH(DEPTH)) bus ();

  stopwatch_lap_cu #(.TIME_W(TIME_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse; on return the FSM has taken the edge that samples it
  task automatic pulse_req(input bit c, input bit r, input bit s, input bit rs);
    bus.i_clear   = c;
    bus.i_runstop = r;
    bus.i_save    = s;
    bus.i_restore = rs;
    tick();
    bus.i_clear   = 1'b0;
    bus.i_runstop = 1'b0;
    bus.i_save    = 1'b0;
    bus.i_restore = 1'b0;
  endtask

  logic [31:0] exp_a [3];
  logic [31:0] exp_b [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.i_clear   = 1'b0;
    bus.i_runstop = 1'b0;
    bus.i_save    = 1'b0;
    bus.i_restore = 1'b0;
    bus.i_time    = '0;
    rst = 1'b0;
    repeat (2) tick();

    // Reset state
    check_eq("rst_runstop", 32'(bus.o_runstop), 32'd0);
    check_eq("rst_count",   32'(bus.o_lap_count), 32'd0);
    check_eq("rst_full",    32'(bus.o_full), 32'd0);
    check_eq("rst_recall",  32'(bus.o_recall_time), 32'd0);
    rst = 1'b1;
    tick();

    // Run / stop toggling: level changes two edges after the pulse
    pulse_req(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("run_edge1", 32'(bus.o_runstop), 32'd0);
    tick();
    check_eq("run_edge2", 32'(bus.o_runstop), 32'd1);
    pulse_req(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("stop", 32'(bus.o_runstop), 32'd0);
    pulse_req(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("rerun", 32'(bus.o_runstop), 32'd1);

    // Three saves while running
    for (int k = 0; k < 3; k++) begin
      bus.i_time = TIME_W'(10 * (k + 1));
      pulse_req(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("save_idle",    32'(bus.o_save), 32'd0);
      check_eq("save_run_in",  32'(bus.o_runstop), 32'd1);
      tick();
      check_eq("save_pulse",   32'(bus.o_save), 32'd1);
      check_eq("save_count",   32'(bus.o_lap_count), 32'(k + 1));
      check_eq("save_run_out", 32'(bus.o_runstop), 32'd1);
    end
    tick();
    check_eq("save_done", 32'(bus.o_save), 32'd0);
    check_eq("save_run_after", 32'(bus.o_runstop), 32'd1);

    // Stop, then four recalls newest-first with wrap
    pulse_req(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("stop2", 32'(bus.o_runstop), 32'd0);
    exp_a[0] = 32'd30;
    exp_a[1] = 32'd20;
    exp_a[2] = 32'd10;
    for (int k = 0; k < 4; k++) begin
      pulse_req(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("rest_idle",   32'(bus.o_restore), 32'd0);
      check_eq("rest_idle_t", 32'(bus.o_recall_time), 32'd0);
      tick();
      check_eq("rest_pulse", 32'(bus.o_restore), 32'd1);
      check_eq("rest_time",  32'(bus.o_recall_time), exp_a[k % 3]);
    end
    tick();
    check_eq("rest_end",   32'(bus.o_restore), 32'd0);
    check_eq("rest_end_t", 32'(bus.o_recall_time), 32'd0);

    // Clear and runstop together in STOP: clear wins, runstop dropped
    pulse_req(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("clr_pulse", 32'(bus.o_clear), 32'd1);
    check_eq("clr_count", 32'(bus.o_lap_count), 32'd0);
    check_eq("clr_run",   32'(bus.o_runstop), 32'd0);
    tick();
    check_eq("clr_done",  32'(bus.o_clear), 32'd0);
    check_eq("clr_run2",  32'(bus.o_runstop), 32'd0);

    // Restore with an empty buffer is ignored
    pulse_req(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("empty_rest", 32'(bus.o_restore), 32'd0);
    tick();
    check_eq("empty_rest2", 32'(bus.o_restore), 32'd0);

    // Five saves into four slots while stopped
    for (int k = 1; k <= 5; k++) begin
      bus.i_time = TIME_W'(k);
      pulse_req(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      if (k < 5) begin
        check_eq("fill_save",  32'(bus.o_save), 32'd1);
        check_eq("fill_count", 32'(bus.o_lap_count), 32'(k));
        check_eq("fill_full",  32'(bus.o_full), 32'(k == 4));
      end else begin
`ifdef LAP_OVERWRITE_EN
        check_eq("ovw_save", 32'(bus.o_save), 32'd1);
        check_eq("ovw_ovf",  32'(bus.o_ovf), 32'd0);
`else
        check_eq("ovf_save", 32'(bus.o_save), 32'd0);
        check_eq("ovf_ovf",  32'(bus.o_ovf), 32'd1);
`endif
        check_eq("full_count", 32'(bus.o_lap_count), 32'd4);
        check_eq("full_flag",  32'(bus.o_full), 32'd1);
        check_eq("full_run",   32'(bus.o_runstop), 32'd0);
      end
    end
    tick();
    check_eq("ovf_done", 32'(bus.o_ovf), 32'd0);

`ifdef LAP_OVERWRITE_EN
    exp_b[0] = 32'd5; exp_b[1] = 32'd4; exp_b[2] = 32'd3; exp_b[3] = 32'd2;
`else
    exp_b[0] = 32'd4; exp_b[1] = 32'd3; exp_b[2] = 32'd2; exp_b[3] = 32'd1;
`endif
    for (int k = 0; k < 4; k++) begin
      pulse_req(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check_eq("full_rest_pulse", 32'(bus.o_restore), 32'd1);
      check_eq("full_rest_time",  32'(bus.o_recall_time), exp_b[k]);
    end

    // Reset asserted in the middle of a save
    pulse_req(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("pre_rst_run", 32'(bus.o_runstop), 32'd1);
    bus.i_time = TIME_W'(77);
    pulse_req(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check_eq("arst_run",   32'(bus.o_runstop), 32'd0);
    check_eq("arst_save",  32'(bus.o_save), 32'd0);
    check_eq("arst_count", 32'(bus.o_lap_count), 32'd0);
    check_eq("arst_full",  32'(bus.o_full), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check_eq("post_rst_count", 32'(bus.o_lap_count), 32'd0);
    check_eq("post_rst_save",  32'(bus.o_save), 32'd0);
    check_eq("post_rst_run",   32'(bus.o_runstop), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
